// File: rtl/audio_avg_filter.sv
// audio_avg_filter: moving-average noise filter between the codec read and write sides.
// Pops one stereo sample, averages each channel over the last N = 2**LOG2_N samples
// and pushes the result back. The sequence is IDLE -> CALC -> WRITE, one sample per
// pass.
// Optional build macro AUDIO_AVG_BYPASS_EN adds a 'bypass' input. When it is high in
// CALC, the output registers load the raw captured samples. The filter state still
// updates while bypassed.
module audio_avg_filter #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned LOG2_N = 3
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              read_ready,
  input  logic [DATA_W-1:0] readdata_left,
  input  logic [DATA_W-1:0] readdata_right,
  output logic              read,
  input  logic              write_ready,
  output logic [DATA_W-1:0] writedata_left,
  output logic [DATA_W-1:0] writedata_right,
  output logic              write
`ifdef AUDIO_AVG_BYPASS_EN
  ,
  input  logic              bypass
`endif
);

  localparam int unsigned N = 1 << LOG2_N;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StCalc  = 2'd1;
  localparam logic [1:0] StWrite = 2'd2;

  localparam logic [LOG2_N-1:0] PtrOne = 1;

  logic [1:0]               state_q, state_d;
  logic [LOG2_N-1:0]        ptr_q, ptr_d;

  // Captured input sample, held from the IDLE edge through CALC.
  logic signed [DATA_W-1:0] samp_l_q, samp_l_d;
  logic signed [DATA_W-1:0] samp_r_q, samp_r_d;

  // Running sums of the scaled history, one per channel.
  logic signed [DATA_W-1:0] acc_l_q, acc_l_d;
  logic signed [DATA_W-1:0] acc_r_q, acc_r_d;

  // History of already-scaled samples. ptr_q points at the oldest entry.
  logic signed [DATA_W-1:0] hist_l_q [N];
  logic signed [DATA_W-1:0] hist_r_q [N];
  logic                     hist_we;

  // Output registers, stable for the whole WRITE state.
  logic signed [DATA_W-1:0] wd_l_q, wd_l_d;
  logic signed [DATA_W-1:0] wd_r_q, wd_r_d;

  logic signed [DATA_W-1:0] scaled_l, scaled_r;
  logic                     use_raw;

  // Divide by N before accumulating so the sum never leaves the DATA_W range.
  // Truncation toward -inf is accepted.
  assign scaled_l = samp_l_q >>> LOG2_N;
  assign scaled_r = samp_r_q >>> LOG2_N;

`ifdef AUDIO_AVG_BYPASS_EN
  assign use_raw = bypass;
`else
  assign use_raw = 1'b0;
`endif

  assign writedata_left  = wd_l_q;
  assign writedata_right = wd_r_q;

  // Next-state, datapath updates and the combinational codec strobes.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    samp_l_d = samp_l_q;
    samp_r_d = samp_r_q;
    acc_l_d  = acc_l_q;
    acc_r_d  = acc_r_q;
    wd_l_d   = wd_l_q;
    wd_r_d   = wd_r_q;
    hist_we  = 1'b0;
    read     = 1'b0;
    write    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Gate with reset_n so no pop is signalled while reset is held.
        read = read_ready & reset_n;
        if (read_ready) begin
          samp_l_d = readdata_left;
          samp_r_d = readdata_right;
          state_d  = StCalc;
        end
      end
      StCalc: begin
        // The oldest entry is subtracted and overwritten in the same cycle.
        acc_l_d = acc_l_q + scaled_l - hist_l_q[ptr_q];
        acc_r_d = acc_r_q + scaled_r - hist_r_q[ptr_q];
        hist_we = 1'b1;
        ptr_d   = ptr_q + PtrOne;
        if (use_raw) begin
          wd_l_d = samp_l_q;
          wd_r_d = samp_r_q;
        end else begin
          wd_l_d = acc_l_d;
          wd_r_d = acc_r_d;
        end
        state_d = StWrite;
      end
      StWrite: begin
        write = write_ready;
        if (write_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Control, sample capture, accumulators and output registers.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      samp_l_q <= '0;
      samp_r_q <= '0;
      acc_l_q  <= '0;
      acc_r_q  <= '0;
      wd_l_q   <= '0;
      wd_r_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      samp_l_q <= samp_l_d;
      samp_r_q <= samp_r_d;
      acc_l_q  <= acc_l_d;
      acc_r_q  <= acc_r_d;
      wd_l_q   <= wd_l_d;
      wd_r_q   <= wd_r_d;
    end
  end

  // History storage: the scaled new sample replaces the oldest entry.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(N); i++) begin
        hist_l_q[i] <= '0;
        hist_r_q[i] <= '0;
      end
    end else if (hist_we) begin
      hist_l_q[ptr_q] <= scaled_l;
      hist_r_q[ptr_q] <= scaled_r;
    end
  end

endmodule

// File: tb/tb_audio_avg_filter.sv
// Directed self-checking bench for audio_avg_filter, default build with N=8.
// Inputs change 1ns after the rising edge. Outputs are sampled on the falling edge.
module tb_audio_avg_filter;

  localparam int unsigned DataW = 24;

  logic             clk;
  logic             reset_n;
  logic             read_ready;
  logic [DataW-1:0] rd_l, rd_r;
  logic             read;
  logic             write_ready;
  logic [DataW-1:0] wd_l, wd_r;
  logic             write;

  int n_checks = 0;
  int n_errors = 0;

  audio_avg_filter #(
    .DATA_W (DataW),
    .LOG2_N (3)
  ) u_dut (
    .CLOCK_50        (clk),
    .reset_n         (reset_n),
    .read_ready      (read_ready),
    .readdata_left   (rd_l),
    .readdata_right  (rd_r),
    .read            (read),
    .write_ready     (write_ready),
    .writedata_left  (wd_l),
    .writedata_right (wd_r),
    .write           (write)
`ifdef AUDIO_AVG_BYPASS_EN
    ,
    .bypass          (1'b0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%06h expected 0x%06h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check both strobes at mid-cycle.
  task automatic strobes(input string tag, input logic e_read, input logic e_write);
    @(negedge clk);
    check({tag, ".read"}, {31'd0, read}, {31'd0, e_read});
    check({tag, ".write"}, {31'd0, write}, {31'd0, e_write});
  endtask

  // One full pass from IDLE with read_ready and write_ready held high.
  // Called 1ns after a rising edge with the DUT in IDLE.
  // Returns at the same point in the following IDLE cycle.
  task automatic xfer(input string tag, input logic [DataW-1:0] l, input logic [DataW-1:0] r,
                      input logic [DataW-1:0] exp_l, input logic [DataW-1:0] exp_r);
    read_ready  = 1'b1;
    write_ready = 1'b1;
    rd_l        = l;
    rd_r        = r;
    strobes({tag, ".t0"}, 1'b1, 1'b0);
    tick();
    // Scramble the inputs to prove the sample was captured.
    rd_l = 24'hABCDEF;
    rd_r = 24'h123456;
    strobes({tag, ".t1"}, 1'b0, 1'b0);
    tick();
    strobes({tag, ".t2"}, 1'b0, 1'b1);
    check({tag, ".wd_l"}, {8'd0, wd_l}, {8'd0, exp_l});
    check({tag, ".wd_r"}, {8'd0, wd_r}, {8'd0, exp_r});
    tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    read_ready = 1'b0;
    reset_n    = 1'b1;
    tick();
  endtask

  logic [DataW-1:0] e;

  initial begin
    // Reset held with both ready inputs high: no strobes, zero outputs.
    reset_n     = 1'b0;
    read_ready  = 1'b1;
    write_ready = 1'b1;
    rd_l        = 24'h000800;
    rd_r        = 24'h7FFFFF;
    for (int i = 0; i < 3; i++) begin
      strobes("rst", 1'b0, 1'b0);
      check("rst.wd_l", {8'd0, wd_l}, 32'h0);
      check("rst.wd_r", {8'd0, wd_r}, 32'h0);
      tick();
    end
    read_ready = 1'b0;
    reset_n    = 1'b1;
    strobes("idle0", 1'b0, 1'b0);
    tick();
    strobes("idle1", 1'b0, 1'b0);
    tick();

    // Step response with 3-cycle handshake timing; each xfer checks read again at T+3.
    for (int k = 1; k <= 10; k++) begin
      e = DataW'((k < 8 ? k : 8) * 32'h100);
      xfer($sformatf("step%0d", k), 24'h000800, 24'h000000, e, 24'h000000);
    end

    // Negative input on the right channel: sign-extended shift ramps down to 0xFFF800.
    for (int k = 1; k <= 10; k++) begin
      e = DataW'(-((k < 8 ? k : 8) * 32'sh100));
      xfer($sformatf("neg%0d", k), 24'h000800, 24'hFFF800, 24'h000800, e);
    end
    // Return to zero: 0xFFF900, 0xFFFA00, ... 0x000000.
    for (int k = 1; k <= 8; k++) begin
      e = DataW'(-32'sh800 + k * 32'sh100);
      xfer($sformatf("ret%0d", k), 24'h000800, 24'h000000, 24'h000800, e);
    end

    // Backpressure: left history holds eight 0x100 entries, right holds eight 0.
    // New sample 0x1000/0x800 gives 0x900/0x100.
    read_ready  = 1'b1;
    write_ready = 1'b0;
    rd_l        = 24'h001000;
    rd_r        = 24'h000800;
    strobes("bp.t0", 1'b1, 1'b0);
    tick();
    strobes("bp.t1", 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 20; i++) begin
      strobes("bp.hold", 1'b0, 1'b0);
      check("bp.wd_l", {8'd0, wd_l}, 32'h000900);
      check("bp.wd_r", {8'd0, wd_r}, 32'h000100);
      tick();
    end
    write_ready = 1'b1;
    read_ready  = 1'b0;
    strobes("bp.release", 1'b0, 1'b1);
    check("bp.rel_wd_l", {8'd0, wd_l}, 32'h000900);
    tick();
    strobes("bp.idle", 1'b0, 1'b0);
    tick();

    // Reset during CALC after four samples: the fifth sample is dropped and history clears.
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      e = DataW'(k * 32'h100);
      xfer($sformatf("pre%0d", k), 24'h000800, 24'h000800, e, e);
    end
    read_ready = 1'b1;
    rd_l       = 24'h000800;
    rd_r       = 24'h000800;
    strobes("mid.t0", 1'b1, 1'b0);
    tick();
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      strobes("mid.rst", 1'b0, 1'b0);
      check("mid.wd_l", {8'd0, wd_l}, 32'h0);
      check("mid.wd_r", {8'd0, wd_r}, 32'h0);
      tick();
    end
    read_ready = 1'b0;
    reset_n    = 1'b1;
    strobes("mid.idle", 1'b0, 1'b0);
    tick();
    strobes("mid.idle2", 1'b0, 1'b0);
    tick();
    xfer("post", 24'h000800, 24'h000800, 24'h000100, 24'h000100);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
